image_gen_axil_regs: RTL and testbench
======================================

# image_gen_axil_regs

AXI4-Lite slave register file for the image generator: four 32-bit software-writable registers (paddle/ball/control words) that the PS programs over S00_AXI and the pixel pipeline consumes. It is the responder end of the AXI4-Lite master traffic issued by the processor or VIP master. It handles independent AW/W acceptance, byte strobes, OKAY responses and frame-synchronous transfer of register values to the video logic.

## Interface

- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register.
- s00_axi_aclk  in  1  the single clock.
- s00_axi_aresetn  in  1  asynchronous, active-low reset.
- s00_axi_awaddr / awprot / awvalid / awready  in/in/in/out  4/3/1/1  write address channel; awprot is ignored.
- s00_axi_wdata / wstrb / wvalid / wready  in/in/in/out  32/4/1/1  write data channel.
- s00_axi_bresp / bvalid / bready  out/out/in  2/1/1  write response channel.
- s00_axi_araddr / arprot / arvalid / arready  in/in/in/out  4/3/1/1  read address channel; arprot is ignored.
- s00_axi_rdata / rresp / rvalid / rready  out/out/out/in  32/2/1/1  read data channel.
- frame_start  in  1  one-cycle pulse from the video timing block at the start of vertical blanking.
- reg0_o … reg3_o  out  32 each  active register values driven to the pixel pipeline.

## Operation

- Storage: shadow registers slv_reg0..3 are software-visible. Reads always return the shadow value.
- Decode: index = addr[3:2]; addr[1:0] is ignored. All four indices are valid. BRESP and RRESP are always 2'b00 (OKAY).
- Write path uses two states.
  - W_IDLE: awready = 1 while no address is latched; wready = 1 while no data is latched. Each channel is latched independently on its handshake, in either order or in the same cycle.
  - When both address and data are held, the write executes: for each byte b, wstrb[b]=1 → byte b is updated, else the byte is kept. The block then moves to W_RESP.
  - W_RESP: awready = wready = 0 and bvalid = 1. On bvalid&&bready, bvalid clears, both latches clear, and the block returns to W_IDLE.
- Read path uses two states.
  - R_IDLE: arready = 1. On arvalid&&arready, rdata is captured from the shadow register and the block moves to R_DATA.
  - R_DATA: arready = 0, rvalid = 1, and rdata is held stable. On rready, the block returns to R_IDLE.
- Read and write paths are fully independent. A read and a write to the same register completing in the same cycle return the pre-write value.
- Single outstanding transaction per direction; no IDs, no bursts.

## Timing

- Reset (asynchronous assert): all shadow regs, reg*_o, rdata = 0; bvalid = rvalid = 0; awready = wready = arready = 0. Readies rise at the first clock edge after ARESETN deasserts.
- Write latency: the later of the AW/W handshakes occurs at edge N. The shadow update and bvalid = 1 both occur at edge N+1.
- Read latency: the AR handshake occurs at edge N; rvalid = 1 with valid rdata at edge N+1.
- bvalid and rvalid, once high, stay high with stable payload until accepted. Back-to-back operation: the next AW/W or AR can be accepted the cycle after B or R is accepted.
- Reset mid-transaction: all latched state is dropped and no response is issued. The master must reissue.
- All readies and valids are registered; there are no combinational input-to-output paths on AXI.

## Configuration

- IMAGE_GEN_SHADOW_EN defined:
  - reg*_o are loaded from slv_reg* on the edge where frame_start = 1.
  - A write and frame_start in the same cycle: reg*_o take the pre-write shadow value, and the new value appears at the next frame_start.
- IMAGE_GEN_SHADOW_EN undefined:
  - reg*_o = slv_reg* continuously, so an update is visible the same edge the write executes.
  - frame_start is ignored.

## Test plan

- Sequential write 0x1,0x2,0x3,0x4 to addresses 0x0,0x4,0x8,0xC with wstrb = 0xF, then read back the same addresses → rdata 0x1,0x2,0x3,0x4, all BRESP/RRESP = 0.
- Write 0xAABBCCDD to 0x4, then 0x11223344 with wstrb = 0x5 → readback 0xAA22CC44.
- W presented 3 cycles before AW at 0x8; second case AW and W in the same cycle → each produces exactly one update, with bvalid one cycle after the later handshake. Hold bready = 0 for 5 cycles → bvalid is held and awready = wready = 0 throughout.
- AR to 0xC with rready held low for 4 cycles → rdata stable, arready = 0 until the R handshake.
- With IMAGE_GEN_SHADOW_EN: write 0x55 to 0x0 → reg0_o stays 0 until frame_start, then reads 0x55. A write coinciding with frame_start → old value is driven out. Without the macro → reg0_o = 0x55 one edge after the W handshake.
- Assert ARESETN = 0 while bvalid = 1 → bvalid = 0 immediately, all regs read 0 after release.

Source files
------------

// File: rtl/image_gen_axil_regs.sv
// rtl/image_gen_axil_regs.sv - AXI4-Lite slave with four 32-bit image generator registers.
// Define IMAGE_GEN_SHADOW_EN to load reg*_o from the shadow registers only on frame_start.
module image_gen_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  input  logic                            frame_start,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o
);
  localparam int NB = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t                      w_state;
  r_state_t                      r_state;
  logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg [4];
  logic                          aw_held;
  logic                          w_held;
  logic [1:0]                    aw_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_l;
  logic [NB-1:0]                 wstrb_l;

  assign s00_axi_bresp = 2'b00;
  assign s00_axi_rresp = 2'b00;

  // Address and data latch independently; the write commits one edge after both are held.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      w_state         <= W_IDLE;
      aw_held         <= 1'b0;
      w_held          <= 1'b0;
      aw_idx          <= '0;
      wdata_l         <= '0;
      wstrb_l         <= '0;
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      for (int i = 0; i < 4; i++) slv_reg[i] <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_held && w_held) begin
            for (int b = 0; b < NB; b++)
              if (wstrb_l[b]) slv_reg[aw_idx][8*b +: 8] <= wdata_l[8*b +: 8];
            s00_axi_bvalid  <= 1'b1;
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            w_state         <= W_RESP;
          end else begin
            if (s00_axi_awvalid && s00_axi_awready) begin
              aw_held <= 1'b1;
              aw_idx  <= s00_axi_awaddr[3:2];
            end
            if (s00_axi_wvalid && s00_axi_wready) begin
              w_held  <= 1'b1;
              wdata_l <= s00_axi_wdata;
              wstrb_l <= s00_axi_wstrb;
            end
            s00_axi_awready <= !(aw_held || (s00_axi_awvalid && s00_axi_awready));
            s00_axi_wready  <= !(w_held || (s00_axi_wvalid && s00_axi_wready));
          end
        end
        W_RESP: begin
          if (s00_axi_bready) begin
            s00_axi_bvalid  <= 1'b0;
            aw_held         <= 1'b0;
            w_held          <= 1'b0;
            s00_axi_awready <= 1'b1;
            s00_axi_wready  <= 1'b1;
            w_state         <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // rdata samples the shadow before any write committing on the same edge.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state         <= R_IDLE;
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s00_axi_arvalid && s00_axi_arready) begin
            s00_axi_rdata   <= slv_reg[s00_axi_araddr[3:2]];
            s00_axi_rvalid  <= 1'b1;
            s00_axi_arready <= 1'b0;
            r_state         <= R_DATA;
          end else begin
            s00_axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s00_axi_rready) begin
            s00_axi_rvalid  <= 1'b0;
            s00_axi_arready <= 1'b1;
            r_state         <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

`ifdef IMAGE_GEN_SHADOW_EN
  logic [C_S_AXI_DATA_WIDTH-1:0] act_reg [4];
  logic                          unused_ok;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int i = 0; i < 4; i++) act_reg[i] <= '0;
    end else if (frame_start) begin
      for (int i = 0; i < 4; i++) act_reg[i] <= slv_reg[i];
    end
  end

  assign reg0_o    = act_reg[0];
  assign reg1_o    = act_reg[1];
  assign reg2_o    = act_reg[2];
  assign reg3_o    = act_reg[3];
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
`else
  logic unused_ok;

  assign reg0_o    = slv_reg[0];
  assign reg1_o    = slv_reg[1];
  assign reg2_o    = slv_reg[2];
  assign reg3_o    = slv_reg[3];
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0],
                       frame_start};
`endif

endmodule

// File: tb/tb_image_gen_axil_regs.sv
// tb/tb_image_gen_axil_regs.sv - Randomized self-checking bench for image_gen_axil_regs.
module tb_image_gen_axil_regs;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        frame_start = 1'b0;
  logic [31:0] reg0_o, reg1_o, reg2_o, reg3_o;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model [4];
  logic [31:0] act [4];

  image_gen_axil_regs dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .frame_start(frame_start),
    .reg0_o(reg0_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .reg3_o(reg3_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish within 2 ms");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r = (r & ~(32'hFF << (8 * b))) | (nw & (32'hFF << (8 * b)));
    return r;
  endfunction

  function automatic logic [31:0] exp_out(input int i);
`ifdef IMAGE_GEN_SHADOW_EN
    return act[i];
`else
    return model[i];
`endif
  endfunction

  task automatic check_outs();
    check("reg0_o", reg0_o, exp_out(0));
    check("reg1_o", reg1_o, exp_out(1));
    check("reg2_o", reg2_o, exp_out(2));
    check("reg3_o", reg3_o, exp_out(3));
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    for (int i = 0; i < 4; i++) act[i] = model[i];
    check_outs();
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_hold,
                          input bit fs_exec, input bit ar_same, input bit complete);
    int          cyc = 0;
    bit          aw_done = 0, w_done = 0, aw_hs, w_hs;
    logic [31:0] exp_r = '0;
    int          idx = int'(addr[3:2]);
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      awaddr  = addr;
      wvalid  = !w_done && (cyc >= w_dly);
      wdata   = data;
      wstrb   = strb;
      aw_hs   = awvalid && awready;
      w_hs    = wvalid && wready;
      @(posedge clk); #1;
      aw_done = aw_done || aw_hs;
      w_done  = w_done || w_hs;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("aw_w_handshake", 32'(aw_done && w_done), 32'd1);
    check("bvalid_early", 32'(bvalid), 32'd0);
    check("awready_latched", 32'(awready), 32'd0);
    check("wready_latched", 32'(wready), 32'd0);
    frame_start = fs_exec;
    if (ar_same) begin
      arvalid = 1'b1;
      araddr  = addr;
      exp_r   = model[idx];
    end
    @(posedge clk); #1;
    frame_start = 1'b0;
    arvalid     = 1'b0;
    if (fs_exec) for (int i = 0; i < 4; i++) act[i] = model[i];
    model[idx] = merge(model[idx], data, strb);
    check("bvalid", 32'(bvalid), 32'd1);
    check("bresp", 32'(bresp), 32'd0);
    check_outs();
    if (ar_same) begin
      check("rvalid_same_cycle", 32'(rvalid), 32'd1);
      check("rdata_prewrite", rdata, exp_r);
    end
    if (!complete) return;
    for (int i = 0; i < b_hold; i++) begin
      @(posedge clk); #1;
      check("bvalid_hold", 32'(bvalid), 32'd1);
      check("awready_in_resp", 32'(awready), 32'd0);
      check("wready_in_resp", 32'(wready), 32'd0);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid_cleared", 32'(bvalid), 32'd0);
    check("awready_back", 32'(awready), 32'd1);
    check("wready_back", 32'(wready), 32'd1);
    if (ar_same) begin
      check("rdata_prewrite_held", rdata, exp_r);
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
      check("rvalid_cleared", 32'(rvalid), 32'd0);
    end
  endtask

  task automatic do_read(input logic [3:0] addr, input int r_hold, output logic [31:0] got);
    int          cyc = 0;
    bit          done = 0, hs;
    logic [31:0] exp = model[int'(addr[3:2])];
    araddr  = addr;
    arvalid = 1'b1;
    while (!done && cyc < 40) begin
      hs = arready;
      @(posedge clk); #1;
      done = hs;
      cyc++;
    end
    arvalid = 1'b0;
    got     = rdata;
    check("ar_handshake", 32'(done), 32'd1);
    check("rvalid", 32'(rvalid), 32'd1);
    check("rdata", rdata, exp);
    check("rresp", 32'(rresp), 32'd0);
    for (int i = 0; i < r_hold; i++) begin
      @(posedge clk); #1;
      check("rvalid_hold", 32'(rvalid), 32'd1);
      check("rdata_stable", rdata, exp);
      check("arready_in_data", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("rvalid_cleared", 32'(rvalid), 32'd0);
    check("arready_back", 32'(arready), 32'd1);
  endtask

  initial begin
    logic [31:0] got;
    for (int i = 0; i < 4; i++) begin
      model[i] = '0;
      act[i]   = '0;
    end
    #22;
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check_outs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("awready_after_rst", 32'(awready), 32'd1);
    check("wready_after_rst", 32'(wready), 32'd1);
    check("arready_after_rst", 32'(arready), 32'd1);

    for (int i = 0; i < 4; i++)
      do_write(4'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      do_read(4'(4 * i), 0, got);
      check("seq_readback", got, 32'(i + 1));
    end

    do_write(4'h4, 32'hAABBCCDD, 4'hF, 0, 0, 0, 0, 0, 1);
    do_write(4'h5, 32'h11223344, 4'h5, 0, 0, 0, 0, 0, 1);
    do_read(4'h6, 0, got);
    check("strb_readback", got, 32'hAA22CC44);

    do_write(4'h8, 32'hCAFE0008, 4'hF, 3, 0, 5, 0, 0, 1);
    do_write(4'h8, 32'h0BAD0008, 4'hF, 0, 0, 0, 0, 0, 1);
    do_write(4'h0, 32'h12345678, 4'hF, 0, 3, 2, 0, 0, 1);
    do_read(4'hC, 4, got);
    check("rd_hold_readback", got, 32'd4);

    do_write(4'h0, 32'h00000055, 4'hF, 0, 0, 0, 0, 0, 1);
    pulse_frame();
    do_write(4'h0, 32'h000000AA, 4'hF, 0, 0, 1, 1, 1, 1);
    pulse_frame();

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0: do_write(4'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1);
        1: do_read(4'($urandom), int'($urandom_range(0, 2)), got);
        default: pulse_frame();
      endcase
    end

    do_write(4'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      model[i] = '0;
      act[i]   = '0;
    end
    check("bvalid_async_rst", 32'(bvalid), 32'd0);
    check("awready_async_rst", 32'(awready), 32'd0);
    check_outs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("awready_rerelease", 32'(awready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      do_read(4'(4 * i), 0, got);
      check("rst_readback", got, 32'd0);
    end
    do_write(4'hC, 32'h600DF00D, 4'hF, 1, 0, 0, 0, 0, 1);
    do_read(4'hC, 1, got);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
